// File: rtl/rettrace_pkg.sv
// rettrace_pkg: shared constants, the buffered entry layout and a prefix-count
// helper for the retire trace collector.
//   SLOTS_C  : retire slots per cycle
//   RT_W     : destination register index width
//   SEQ_W    : sequence number width
//   DATA_W_C : retired result width
//   OFF_W    : width of a per-slot write offset / group size (0..SLOTS_C)
// Optional feature macro used by this slice: RETTRACE_LASTWR_EN.
package rettrace_pkg;

  localparam int SLOTS_C  = 9;
  localparam int RT_W     = 6;
  localparam int SEQ_W    = 32;
  localparam int DATA_W_C = 65;
  localparam int OFF_W    = 4;

  typedef struct packed {
    logic [3:0]          slot;
    logic [RT_W-1:0]     rT;
    logic                rT_en;
    logic [DATA_W_C-1:0] data;
  } rettrace_entry_t;

  // Number of set bits in v[upto-1:0]; upto = SLOTS_C yields the full popcount.
  function automatic logic [OFF_W-1:0] prefix_count(input logic [SLOTS_C-1:0] v,
                                                    input int upto);
    logic [OFF_W-1:0] c;
    c = {OFF_W{1'b0}};
    for (int i = 0; i < SLOTS_C; i++) begin
      c = c + ((i < upto) ? {{(OFF_W-1){1'b0}}, v[i]} : {OFF_W{1'b0}});
    end
    return c;
  endfunction

endpackage

// File: rtl/rettrace_compact.sv
// rettrace_compact: combinational compaction of one retire group.
// Ports:
//   en    in  SLOTS_C        per-slot retire enable
//   rT    in  SLOTS_C*RT_W   per-slot destination register
//   rT_en in  SLOTS_C        per-slot "writes rT" qualifier
//   keep  out SLOTS_C        slots that actually enter the buffer
//   offs  out SLOTS_C*OFF_W  write offset of each slot relative to tail
//   n     out OFF_W          number of kept slots
// Macro RETTRACE_LASTWR_EN: when defined, a slot is dropped if a higher enabled
// slot of the same group writes the same register, so only the last write per
// register per cycle is traced.
module rettrace_compact import rettrace_pkg::*; (
  input  logic [SLOTS_C-1:0]       en,
  input  logic [SLOTS_C*RT_W-1:0]  rT,
  input  logic [SLOTS_C-1:0]       rT_en,
  output logic [SLOTS_C-1:0]       keep,
  output logic [SLOTS_C*OFF_W-1:0] offs,
  output logic [OFF_W-1:0]         n
);

`ifdef RETTRACE_LASTWR_EN
  localparam logic LASTWR_ON = 1'b1;
`else
  localparam logic LASTWR_ON = 1'b0;
`endif

  logic [SLOTS_C-1:0] sup_s;

  // Mark slot k as superseded when a later enabled slot writes the same rT.
  always_comb begin
    sup_s = {SLOTS_C{1'b0}};
    for (int k = 0; k < SLOTS_C; k++) begin
      for (int j = 0; j < SLOTS_C; j++) begin
        sup_s[k] = sup_s[k] | ((j > k) && en[j] && rT_en[j] && rT_en[k] &&
                               (rT[j*RT_W +: RT_W] == rT[k*RT_W +: RT_W]));
      end
    end
  end

  // Kept mask, per-slot prefix offsets and group size.
  always_comb begin
    keep = en & ~(sup_s & {SLOTS_C{LASTWR_ON}});
    offs = {(SLOTS_C*OFF_W){1'b0}};
    for (int k = 0; k < SLOTS_C; k++) begin
      offs[k*OFF_W +: OFF_W] = prefix_count(keep, k);
    end
    n = prefix_count(keep, SLOTS_C);
  end

endmodule

// File: rtl/retire_trace_collector.sv
// retire_trace_collector: captures up to SLOTS retire slots per cycle, compacts
// the enabled ones in slot order into a circular buffer and streams them out one
// per cycle with a sequence number. Provides a sticky overflow flag and a sticky
// no-retire watchdog.
// Ports:
//   clk, rst (synchronous, active-low)
//   ret_en/ret_rT/ret_data/ret_rT_en : retire slot inputs
//   in_can    : registered, at least SLOTS entries free
//   out_valid/out_ready/out_slot/out_rT/out_rT_en/out_data/out_seq : stream
//   overflow, wdog_fire : sticky error flags, cleared by clr_err
// Macro RETTRACE_LASTWR_EN (see rettrace_compact) enables last-writer filtering.
module retire_trace_collector import rettrace_pkg::*; #(
  parameter int SLOTS      = SLOTS_C,
  parameter int DEPTH      = 64,
  parameter int WDOG_LIMIT = 2000,
  parameter int DATA_W     = DATA_W_C
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SLOTS-1:0]        ret_en,
  input  logic [SLOTS*RT_W-1:0]   ret_rT,
  input  logic [SLOTS*DATA_W-1:0] ret_data,
  input  logic [SLOTS-1:0]        ret_rT_en,
  output logic                    in_can,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_slot,
  output logic [RT_W-1:0]         out_rT,
  output logic                    out_rT_en,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEQ_W-1:0]        out_seq,
  output logic                    overflow,
  output logic                    wdog_fire,
  input  logic                    clr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int WD_W  = $clog2(WDOG_LIMIT + 1);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] SLOTS_P = PTR_W'(SLOTS);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WDOG_LIMIT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG_LIMIT - 1);

  // Pointers carry a wrap bit: tail - head is the occupancy 0..DEPTH.
  logic [PTR_W-1:0] head_r, tail_r;
  logic [SEQ_W-1:0] seq_r;
  logic             in_can_r, ovf_r, fire_r;
  logic [WD_W-1:0]  wd_r;
  rettrace_entry_t  mem_r [DEPTH];

  logic [SLOTS_C-1:0]       keep_s;
  logic [SLOTS_C*OFF_W-1:0] offs_s;
  logic [OFF_W-1:0]         n_s;
  logic [PTR_W-1:0]         count_s, free_s, n_ext_s, push_n_s, count_next_s;
  logic                     fits_s, ovf_set_s, valid_s, pop_s, idle_s, wd_set_s;
  logic [IDX_W-1:0]         wr_idx_s [SLOTS_C];
  rettrace_entry_t          wr_ent_s [SLOTS_C];
  logic [SLOTS_C-1:0]       wr_en_s;
  rettrace_entry_t          head_ent_s;

  rettrace_compact u_compact (
    .en    (ret_en),
    .rT    (ret_rT),
    .rT_en (ret_rT_en),
    .keep  (keep_s),
    .offs  (offs_s),
    .n     (n_s)
  );

  // Occupancy, all-or-nothing admission against pre-pop space, pop and watchdog.
  always_comb begin
    count_s      = tail_r - head_r;
    free_s       = DEPTH_P - count_s;
    n_ext_s      = {{(PTR_W-OFF_W){1'b0}}, n_s};
    fits_s       = (n_ext_s <= free_s);
    ovf_set_s    = (n_s != {OFF_W{1'b0}}) && !fits_s;
    push_n_s     = fits_s ? n_ext_s : {PTR_W{1'b0}};
    valid_s      = (count_s != {PTR_W{1'b0}});
    pop_s        = valid_s && out_ready;
    count_next_s = count_s + push_n_s - {{(PTR_W-1){1'b0}}, pop_s};
    idle_s       = (n_s == {OFF_W{1'b0}});
    wd_set_s     = idle_s && (wd_r == WD_LAST);
  end

  // Per-slot buffer address and entry image for the admitted group.
  always_comb begin
    for (int k = 0; k < SLOTS_C; k++) begin
      wr_idx_s[k]       = tail_r[IDX_W-1:0] + IDX_W'(offs_s[k*OFF_W +: OFF_W]);
      wr_ent_s[k].slot  = 4'(k);
      wr_ent_s[k].rT    = ret_rT[k*RT_W +: RT_W];
      wr_ent_s[k].rT_en = ret_rT_en[k];
      wr_ent_s[k].data  = ret_data[k*DATA_W +: DATA_W];
      wr_en_s[k]        = keep_s[k] & fits_s & rst;
    end
  end

  // Buffer storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    for (int k = 0; k < SLOTS_C; k++) begin
      if (wr_en_s[k]) begin
        mem_r[wr_idx_s[k]] <= wr_ent_s[k];
      end
    end
  end

  // Pointers, sequence number, in_can and sticky error state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      seq_r    <= {SEQ_W{1'b0}};
      in_can_r <= 1'b1;
      ovf_r    <= 1'b0;
      fire_r   <= 1'b0;
      wd_r     <= {WD_W{1'b0}};
    end else begin
      tail_r   <= tail_r + push_n_s;
      head_r   <= head_r + {{(PTR_W-1){1'b0}}, pop_s};
      seq_r    <= seq_r + {{(SEQ_W-1){1'b0}}, pop_s};
      in_can_r <= ((DEPTH_P - count_next_s) >= SLOTS_P);
      // Set beats clear when both happen in one cycle.
      ovf_r    <= ovf_set_s | (ovf_r & ~clr_err);
      fire_r   <= wd_set_s  | (fire_r & ~clr_err);
      if (clr_err || !idle_s) begin
        wd_r <= {WD_W{1'b0}};
      end else if (wd_r != WD_MAX) begin
        wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
      end else begin
        wd_r <= wd_r;
      end
    end
  end

  assign head_ent_s = mem_r[head_r[IDX_W-1:0]];
  assign out_valid  = valid_s;
  assign out_slot   = head_ent_s.slot;
  assign out_rT     = head_ent_s.rT;
  assign out_rT_en  = head_ent_s.rT_en;
  assign out_data   = head_ent_s.data;
  assign out_seq    = seq_r;
  assign in_can     = in_can_r;
  assign overflow   = ovf_r;
  assign wdog_fire  = fire_r;

endmodule

// File: tb/tb_retire_trace_collector.sv
// Self-checking bench for retire_trace_collector: directed scenarios plus a
// randomized phase, all compared each cycle against a queue-based reference.
module tb_retire_trace_collector;

  localparam int SLOTS      = 9;
  localparam int DEPTH      = 64;
  localparam int WDOG_LIMIT = 2000;
  localparam int DATA_W     = 65;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [SLOTS-1:0]        ret_en, ret_rT_en;
  logic [SLOTS*6-1:0]      ret_rT;
  logic [SLOTS*DATA_W-1:0] ret_data;
  logic                    in_can, out_valid, out_ready, out_rT_en;
  logic [3:0]              out_slot;
  logic [5:0]              out_rT;
  logic [DATA_W-1:0]       out_data;
  logic [31:0]             out_seq;
  logic                    overflow, wdog_fire, clr_err;

  retire_trace_collector #(.SLOTS(SLOTS), .DEPTH(DEPTH), .WDOG_LIMIT(WDOG_LIMIT),
                           .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ret_en(ret_en), .ret_rT(ret_rT), .ret_data(ret_data),
    .ret_rT_en(ret_rT_en), .in_can(in_can), .out_valid(out_valid),
    .out_ready(out_ready), .out_slot(out_slot), .out_rT(out_rT),
    .out_rT_en(out_rT_en), .out_data(out_data), .out_seq(out_seq),
    .overflow(overflow), .wdog_fire(wdog_fire), .clr_err(clr_err)
  );

  typedef struct {
    logic [3:0]        slot;
    logic [5:0]        rT;
    logic              rT_en;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference state
  ent_t        mq[$];
  int unsigned m_seq;
  bit          m_ovf, m_fire;
  int          m_wd;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    ret_en    = '0;
    ret_rT_en = '0;
    ret_rT    = '0;
    ret_data  = '0;
  endtask

  task automatic set_slot(input int k, input logic [5:0] rt, input logic rte,
                          input logic [DATA_W-1:0] d);
    ret_en[k]               = 1'b1;
    ret_rT[k*6 +: 6]        = rt;
    ret_rT_en[k]            = rte;
    ret_data[k*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  task automatic fill_all();
    for (int k = 0; k < SLOTS; k++)
      set_slot(k, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rand_data());
  endtask

  // One clock: build the expected group from the spec rules, apply the edge to
  // the reference, then compare all DUT outputs 1 time unit after the edge.
  task automatic tick();
    ent_t g[$];
    ent_t e;
    bit   sup, pop, fits, set_w;
    for (int k = 0; k < SLOTS; k++) begin
      if (ret_en[k]) begin
        sup = 1'b0;
`ifdef RETTRACE_LASTWR_EN
        if (ret_rT_en[k])
          for (int j = k + 1; j < SLOTS; j++)
            if (ret_en[j] && ret_rT_en[j] && ret_rT[j*6 +: 6] == ret_rT[k*6 +: 6]) sup = 1'b1;
`endif
        if (!sup) begin
          e.slot  = 4'(k);
          e.rT    = ret_rT[k*6 +: 6];
          e.rT_en = ret_rT_en[k];
          e.data  = ret_data[k*DATA_W +: DATA_W];
          g.push_back(e);
        end
      end
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete(); m_seq = 0; m_ovf = 0; m_fire = 0; m_wd = 0;
    end else begin
      pop  = (mq.size() != 0) && out_ready;
      fits = g.size() <= (DEPTH - mq.size());
      if (pop) begin void'(mq.pop_front()); m_seq++; end
      if (fits) foreach (g[i]) mq.push_back(g[i]);
      if (!fits) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
      set_w = (g.size() == 0) && (m_wd == WDOG_LIMIT - 1);
      if (clr_err || g.size() != 0) m_wd = 0;
      else if (m_wd < WDOG_LIMIT) m_wd++;
      if (set_w) m_fire = 1'b1; else if (clr_err) m_fire = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_can", in_can, (DEPTH - mq.size()) >= SLOTS);
    chk("overflow", overflow, m_ovf);
    chk("wdog_fire", wdog_fire, m_fire);
    if (mq.size() != 0) begin
      chk("out_slot", out_slot, mq[0].slot);
      chk("out_rT", out_rT, mq[0].rT);
      chk("out_rT_en", out_rT_en, mq[0].rT_en);
      chk("out_data", out_data, mq[0].data);
      chk("out_seq", out_seq, m_seq);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_in();
    tick();
    rst = 1'b1;
  endtask

  logic [3:0] comp_sl [4] = '{4'd0, 4'd2, 4'd5, 4'd8};
`ifdef RETTRACE_LASTWR_EN
  int lw_sl[$] = '{3, 6};
`else
  int lw_sl[$] = '{1, 3, 4, 6};
`endif

  initial begin
    rst = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    clear_in();

    // Reset hold with every slot enabled
    fill_all();
    repeat (3) tick();
    chk("rst_hold_valid", out_valid, 1'b0);
    chk("rst_hold_in_can", in_can, 1'b1);
    chk("rst_hold_seq", out_seq, 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_release_valid", out_valid, 1'b1);
    chk("rst_release_slot", out_slot, 4'd0);

    // Compaction order
    do_reset();
    set_slot(0, 6'd3, 1'b1, 65'd100);
    set_slot(2, 6'd7, 1'b1, 65'd102);
    set_slot(5, 6'd9, 1'b0, 65'd105);
    set_slot(8, 6'd1, 1'b1, 65'd108);
    out_ready = 1'b1;
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      chk("comp_slot", out_slot, comp_sl[i]);
      chk("comp_seq", out_seq, 32'(i));
      tick();
    end
    chk("comp_drained", out_valid, 1'b0);

    // Full and overflow
    do_reset();
    out_ready = 1'b0;
    for (int g = 1; g <= 8; g++) begin
      fill_all();
      tick();
      if (g == 6) chk("full_in_can_g6", in_can, 1'b1);
      if (g == 7) chk("full_in_can_g7", in_can, 1'b0);
      if (g == 7) chk("full_overflow_g7", overflow, 1'b0);
    end
    chk("full_overflow_g8", overflow, 1'b1);
    chk("full_head_seq", out_seq, 32'd0);
    clear_in();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("full_clr", overflow, 1'b0);
    out_ready = 1'b1;
    repeat (64) tick();
    chk("full_drained", out_valid, 1'b0);

    // Pointer wrap with data = sequence index
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      clear_in();
      set_slot($urandom_range(0, SLOTS - 1), 6'($urandom_range(0, 63)), 1'b1, 65'(i));
      tick();
      chk("wrap_data", out_data, 65'(i));
      chk("wrap_seq", out_seq, 32'(i));
    end
    clear_in();
    tick();

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      clear_in();
      ret_en    = 9'($urandom());
      ret_rT_en = 9'($urandom());
      for (int k = 0; k < SLOTS; k++) begin
        ret_rT[k*6 +: 6] = 6'($urandom_range(0, 7));
        ret_data[k*DATA_W +: DATA_W] = rand_data();
      end
      out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 31) == 0);
      rst       = (i == 450) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1; clr_err = 1'b0;

    // Watchdog
    clear_in();
    out_ready = 1'b1;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    repeat (WDOG_LIMIT - 1) tick();
    chk("wdog_1999_idle", wdog_fire, 1'b0);
    set_slot(0, 6'd2, 1'b1, 65'd7);
    tick();
    clear_in();
    chk("wdog_after_retire", wdog_fire, 1'b0);
    repeat (WDOG_LIMIT) tick();
    chk("wdog_fire_2000", wdog_fire, 1'b1);
    repeat (5) tick();
    chk("wdog_sticky", wdog_fire, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("wdog_clr", wdog_fire, 1'b0);

    // Last-writer filtering
    do_reset();
    out_ready = 1'b1;
    set_slot(1, 6'd5, 1'b1, 65'd11);
    set_slot(3, 6'd5, 1'b0, 65'd13);
    set_slot(4, 6'd5, 1'b1, 65'd14);
    set_slot(6, 6'd5, 1'b1, 65'd16);
    tick();
    clear_in();
    for (int i = 0; i < lw_sl.size(); i++) begin
      chk("lastwr_slot", out_slot, 4'(lw_sl[i]));
      tick();
    end
    chk("lastwr_drained", out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
